// File: rtl/arm_pkg.sv
// Shared ARMv4 core types and constants.
// Used by the fetch stage and its prefetch buffer.
package arm_pkg;

  localparam int          WORD_W               = 32;
  localparam int          PF_DEPTH_DEFAULT     = 2;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small in-order buffer of fetched instructions between memory and decode.
// Flush has priority over push and pop; pointers wrap naturally (power-of-2 depth).
module prefetch_fifo
  import arm_pkg::*;
#(
  parameter int PF_DEPTH = PF_DEPTH_DEFAULT,
  localparam int PTR_W   = $clog2(PF_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PF_DEPTH);

  fetch_entry_t     mem_q [PF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Overflow/underflow guards keep the pointers coherent even if a caller misbehaves.
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ARMv4 instruction fetch: owns the fetch PC, issues word reads, buffers them
// in the prefetch FIFO and hands them to decode in order with their PC and PC+8.
module fetch_unit
  import arm_pkg::*;
#(
  parameter int          PF_DEPTH     = PF_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus8
);

  localparam int               CNT_W   = $clog2(PF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PF_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             transfer;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // A redirect suppresses the request so nothing is accepted in the flush cycle.
  assign imem_req   = ~rst & ~fifo_full & ~branch_valid;
  assign imem_addr  = fetch_pc_q;
  assign transfer   = imem_req & imem_ack;

  assign inst_valid = ~fifo_empty;
  assign pop        = inst_valid & ~stall & ~branch_valid;

  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = fetch_pc_q;

  // Zero the decode outputs while empty so a flushed head never leaks through.
  assign inst     = inst_valid ? head_entry.inst : '0;
  assign inst_pc  = inst_valid ? head_entry.pc   : '0;
  assign pc_plus8 = inst_pc + 32'd8;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_valid) begin
      fetch_pc_d = word_align(branch_target);
    end else if (transfer) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_VECTOR;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  prefetch_fifo #(
    .PF_DEPTH (PF_DEPTH)
  ) u_prefetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (transfer),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (branch_valid),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Occupancy sanity: full and empty are exclusive and count never exceeds depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_full && fifo_empty) && (fifo_count <= DEPTH_C));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected decode-side instructions,
// a negedge monitor pops and compares each instruction decode actually consumes.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus8;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc8;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fetch_unit #(.PF_DEPTH(2), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .stall         (stall),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .pc_plus8      (pc_plus8)
  );

  always #5 clk = ~clk;

  // Instruction memory: the word at an address is that address xor a fixed tag.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] word, input logic [31:0] pc8);
    exp_t e;
    e.pc   = pc;
    e.inst = word;
    e.pc8  = pc8;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every instruction decode takes must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && !stall && !branch_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop: unexpected instruction inst_pc=%h inst=%h", inst_pc, inst);
      end else begin
        e = sb.pop_front();
        check("pop.inst_pc", inst_pc, e.pc);
        check("pop.inst", inst, e.inst);
        check("pop.pc_plus8", pc_plus8, e.pc8);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst.imem_req", 32'(imem_req), 32'd0);
    check("rst.inst_valid", 32'(inst_valid), 32'd0);
    check("rst.inst", inst, 32'h0);
    check("rst.inst_pc", inst_pc, 32'h0);
    check("rst.pc_plus8", pc_plus8, 32'h8);
    step();

    // 1: free run
    imem_ack = 1'b1;
    expect_inst(32'h0, 32'hA5A5_0000, 32'h8);
    expect_inst(32'h4, 32'hA5A5_0004, 32'hC);
    expect_inst(32'h8, 32'hA5A5_0008, 32'h10);
    expect_inst(32'hC, 32'hA5A5_000C, 32'h14);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1.imem_addr", imem_addr, 32'(4 * i));
      step();
    end
    rst = 1'b1;

    // 2: stalled from reset
    stall = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t2.req0", 32'(imem_req), 32'd1);
    check("t2.addr0", imem_addr, 32'h0);
    step();
    @(negedge clk);
    check("t2.addr1", imem_addr, 32'h4);
    check("t2.inst_pc", inst_pc, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2.full_req", 32'(imem_req), 32'd0);
      check("t2.hold_pc", inst_pc, 32'h0);
      step();
    end
    expect_inst(32'h0, 32'hA5A5_0000, 32'h8);
    expect_inst(32'h4, 32'hA5A5_0004, 32'hC);
    stall = 1'b0;
    @(negedge clk);
    check("t2.req_still_full", 32'(imem_req), 32'd0);
    step();
    @(negedge clk);
    check("t2.req8", 32'(imem_req), 32'd1);
    check("t2.addr8", imem_addr, 32'h8);
    step();
    rst = 1'b1;

    // 3: memory holds off ack
    imem_ack = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3.req", 32'(imem_req), 32'd1);
      check("t3.addr", imem_addr, 32'h0);
      check("t3.inst_valid", 32'(inst_valid), 32'd0);
      step();
    end
    imem_ack = 1'b1;
    expect_inst(32'h0, 32'hA5A5_0000, 32'h8);
    @(negedge clk);
    check("t3.ack_addr", imem_addr, 32'h0);
    step();
    @(negedge clk);
    check("t3.inst_valid_after_ack", 32'(inst_valid), 32'd1);
    step();
    rst = 1'b1;

    // 4: redirect with 0 and 4 buffered
    stall = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0103;
    @(negedge clk);
    check("t4.req_in_branch", 32'(imem_req), 32'd0);
    step();
    branch_valid = 1'b0;
    @(negedge clk);
    check("t4.inst_valid", 32'(inst_valid), 32'd0);
    check("t4.addr", imem_addr, 32'h0000_0100);
    step();
    expect_inst(32'h0000_0100, 32'hA5A5_0100, 32'h0000_0108);
    stall = 1'b0;
    @(negedge clk);
    step();

    // 5: redirect to the top of the address space
    branch_valid  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    expect_inst(32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0000_0004);
    expect_inst(32'h0000_0000, 32'hA5A5_0000, 32'h0000_0008);
    @(negedge clk);
    check("t5.req_in_branch", 32'(imem_req), 32'd0);
    step();
    branch_valid = 1'b0;
    @(negedge clk);
    check("t5.addr_top", imem_addr, 32'hFFFF_FFFC);
    check("t5.inst_valid", 32'(inst_valid), 32'd0);
    step();
    @(negedge clk);
    check("t5.addr_wrap", imem_addr, 32'h0);
    check("t5.pc_plus8_wrap", pc_plus8, 32'h4);
    step();
    @(negedge clk);
    check("t5.addr_after_wrap", imem_addr, 32'h4);
    step();

    // 6: reset lands on a cycle with a transfer in progress
    check("t6.req_before", 32'(imem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6.req", 32'(imem_req), 32'd0);
    check("t6.inst_valid", 32'(inst_valid), 32'd0);
    check("t6.inst", inst, 32'h0);
    check("t6.inst_pc", inst_pc, 32'h0);
    check("t6.pc_plus8", pc_plus8, 32'h8);
    step();
    rst = 1'b0;
    expect_inst(32'h0, 32'hA5A5_0000, 32'h8);
    @(negedge clk);
    check("t6.addr", imem_addr, 32'h0);
    check("t6.inst_valid_after", 32'(inst_valid), 32'd0);
    step();
    @(negedge clk);
    step();
    stall = 1'b1;
    step();
    step();
    check("sb.leftover", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
